instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle datapath/controller pair. It owns the program counter and issues word reads to instruction memory over a request/acknowledge handshake that tolerates variable latency. Returned words are buffered in a small FIFO and presented to decode with valid/ready, together with pre-sliced opcode/funct fields. A redirect input (branch/jump target) flushes the buffer and restarts fetch, including safe disposal of an in-flight read.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- DEPTH, 2, instruction FIFO entries; power of two, ≥ 2
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- imem_req  out  1  read request; registered; held high until imem_ack
- imem_addr  out  32  word address of request; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse, valid only while imem_req=1; data accepted same edge
- imem_rdata  in  32  instruction word, valid with imem_ack
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] forced to 0 internally
- inst_valid  out  1  FIFO head holds a valid instruction
- inst_ready  in  1  decode accepts head this cycle
- inst  out  32  FIFO head instruction word
- inst_pc  out  32  PC of FIFO head instruction
- inst_opcode  out  7  inst[6:0]
- inst_funct3  out  3  inst[14:12]
- inst_funct7  out  7  inst[31:25]

## Operation
- State machine, three states:
  - IDLE: no request outstanding. Issue when room exists: next state WAIT, imem_req←1, imem_addr←fetch_pc.
  - WAIT: request outstanding. On imem_ack: push {imem_rdata, imem_addr}, fetch_pc←imem_addr+4. If room remains after this cycle's push/pop, stay WAIT with imem_addr←new fetch_pc (back-to-back); else IDLE, imem_req←0.
  - KILL: request outstanding but stale. Hold imem_req/imem_addr unchanged; on imem_ack discard data, then behave as IDLE with fetch_pc = saved redirect target.
- Room: count_next + (outstanding request) < DEPTH, where count_next = count + push − pop. At most one request is ever outstanding, so the FIFO never overflows; a push is never refused.
- Pop: inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, any state):
  - FIFO flushed (count←0); any same-cycle push or pop is ignored.
  - IDLE, or WAIT with imem_ack in the same cycle: fetch_pc←redirect_pc, go IDLE, imem_req←0 for one cycle, then request redirect_pc.
  - WAIT without ack: go KILL and latch target.
  - KILL: overwrite the latched target; stay KILL.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- inst_opcode/funct3/funct7 are combinational slices of inst. They are don't-care when inst_valid=0.

## Timing
- Reset values: state IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0.
- Reset asserted mid-request: everything returns to reset values on that edge; a later imem_ack while imem_req=0 is ignored.
- First request: imem_req=1 in the first cycle after reset deasserts.
- Latency: imem_ack at edge N → inst_valid=1 from edge N (visible cycle N+1), provided FIFO was empty.
- Zero-wait memory (ack in the cycle req first seen): one instruction per cycle sustained while inst_ready=1.
- Redirect at edge N: inst_valid=0 in cycle N+1. Earliest imem_req for the target is cycle N+2 from IDLE/WAIT+ack, or two cycles after the killed ack from KILL.

## Test plan
- Reset/streaming: RESET_PC=0, memory acks in same cycle, inst_ready=1 → inst_pc sequence 0,4,8,… one per cycle; inst = stored words; opcode/funct slices match.
- Backpressure: inst_ready=0 for 10 cycles with DEPTH=2 → exactly 2 words buffered, imem_req=0; release → PCs 0,4,8 delivered in order, none lost or duplicated.
- Variable latency: ack delays 3,0,5 cycles → imem_addr stable while req high; inst_pc 0,4,8 in order.
- Redirect during outstanding read: redirect_pc=0x100 while waiting on 0x8 → imem_addr stays 0x8 until ack, that data never appears; next request 0x100; first inst_pc=0x100.
- Simultaneous redirect+ack and redirect+pop: redirect_pc=0x203 → acked word dropped, FIFO empty next cycle, next imem_addr=0x200.
- Wrap and mid-op reset: redirect to 0xFFFF_FFFC → following inst_pc=0x0; assert reset during WAIT → imem_req=0, inst_valid=0 next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/ack handshake and buffers
// returned words in a small FIFO presented to decode with valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  inst_opcode,
  output logic [2:0]  inst_funct3,
  output logic [6:0]  inst_funct7
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StKill} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     target_q, target_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];

  logic [31:0] redirect_tgt;
  logic        unused_pc_bits;
  logic        acked;
  logic        push;
  logic        pop;
  logic        room;

  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign inst_valid     = (count_q != '0);
  assign acked          = req_q && imem_ack;
  // Only a live (non-killed) response is buffered; a redirect discards it.
  assign push           = (state_q == StWait) && acked && !redirect_valid;
  assign pop            = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Evaluated only when no request will remain outstanding after this edge.
  assign room = (count_d < DepthCnt);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    req_d      = req_q;
    addr_d     = addr_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
        end else if (room) begin
          state_d = StWait;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      StWait: begin
        if (acked) begin
          state_d = StIdle;
          req_d   = 1'b0;
          if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
          end else begin
            fetch_pc_d = addr_q + 32'd4;
            if (room) begin
              state_d = StWait;
              req_d   = 1'b1;
              addr_d  = addr_q + 32'd4;
            end
          end
        end else if (redirect_valid) begin
          state_d  = StKill;
          target_d = redirect_tgt;
        end
      end
      StKill: begin
        // A redirect coinciding with the stale ack wins over the latched target.
        if (acked) begin
          state_d    = StIdle;
          req_d      = 1'b0;
          fetch_pc_d = redirect_valid ? redirect_tgt : target_q;
        end else if (redirect_valid) begin
          target_d = redirect_tgt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]   <= addr_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst        = inst_valid ? data_q[rd_ptr_q] : '0;
  assign inst_pc     = inst_valid ? pc_q[rd_ptr_q] : '0;
  assign inst_opcode = inst[6:0];
  assign inst_funct3 = inst[14:12];
  assign inst_funct7 = inst[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run, checked
// against an in-order stream model of the instruction sequence.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Depth   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  inst_opcode;
  logic [2:0]  inst_funct3;
  logic [6:0]  inst_funct7;

  instr_fetch_unit #(
    .RESET_PC (ResetPc),
    .DEPTH    (Depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode),
    .inst_funct3    (inst_funct3),
    .inst_funct7    (inst_funct7)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: consumer pointer, fetch pointer, words buffered, stale-request tracking.
  logic [31:0] exp_pc;
  logic [31:0] fetch_ptr;
  logic [31:0] tgt_pc;
  logic [31:0] stale_tgt;
  int          buffered;
  bit          stale;
  int          stage;
  bit          prev_req;
  bit          prev_ack;
  logic [31:0] prev_addr;
  int          lat_cnt;
  bit          lat_loaded;
  int          def_lat;
  bit          rand_lat;
  bit          rogue;
  int          lat_q[$];
  int          pops;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    logic        ack_now;
    logic        pop_now;
    logic        req_now;
    logic [31:0] w;
    logic [31:0] tgt;
    if (stage == 1) begin
      check("req_low_after_redirect", 32'(imem_req), 32'd0);
      stage = 2;
    end else if (stage == 2) begin
      check("req_target", 32'(imem_req), 32'd1);
      check("addr_target", imem_addr, tgt_pc);
      stage = 0;
    end
    if (prev_req && !prev_ack) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, prev_addr);
    end
    check("valid_vs_model", 32'(inst_valid), 32'(buffered != 0));
    if (buffered == int'(Depth)) check("req_low_full", 32'(imem_req), 32'd0);

    ack_now    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    req_now    = imem_req;
    if (imem_req) begin
      if (!lat_loaded) begin
        if (lat_q.size() > 0) lat_cnt = lat_q.pop_front();
        else if (rand_lat)    lat_cnt = int'($urandom_range(0, 4));
        else                  lat_cnt = def_lat;
        lat_loaded = 1'b1;
      end
      if (lat_cnt == 0) begin
        ack_now    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        lat_loaded = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (rogue) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0BAD;
    end

    pop_now = (buffered != 0) && inst_ready && !redirect_valid;
    if (pop_now) begin
      w = mem_word(exp_pc);
      check("inst_pc", inst_pc, exp_pc);
      check("inst_word", inst, w);
      check("opcode", 32'(inst_opcode), 32'(w[6:0]));
      check("funct3", 32'(inst_funct3), 32'(w[14:12]));
      check("funct7", 32'(inst_funct7), 32'(w[31:25]));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    prev_req  = req_now;
    prev_addr = imem_addr;
    prev_ack  = ack_now;

    @(posedge clk);
    if (redirect_valid) begin
      tgt      = {redirect_pc[31:2], 2'b00};
      buffered = 0;
      exp_pc   = tgt;
      if (req_now && !ack_now) begin
        stale     = 1'b1;
        stale_tgt = tgt;
      end else begin
        stale     = 1'b0;
        fetch_ptr = tgt;
        tgt_pc    = tgt;
        stage     = 1;
      end
    end else begin
      if (ack_now) begin
        if (stale) begin
          stale     = 1'b0;
          fetch_ptr = stale_tgt;
          tgt_pc    = stale_tgt;
          stage     = 1;
        end else begin
          check("fetch_addr", prev_addr, fetch_ptr);
          fetch_ptr = fetch_ptr + 32'd4;
          buffered++;
        end
      end
      if (pop_now) buffered--;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, ResetPc);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    reset      = 1'b0;
    exp_pc     = ResetPc;
    fetch_ptr  = ResetPc;
    buffered   = 0;
    stale      = 1'b0;
    stage      = 0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    lat_loaded = 1'b0;
    lat_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, ResetPc);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (pops < target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(pops >= target), 32'd1);
  endtask

  initial begin
    int p0;
    reset          = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    def_lat        = 0;
    rand_lat       = 1'b0;
    rogue          = 1'b0;
    pops           = 0;
    @(negedge clk);

    // Zero-wait streaming: one instruction per cycle.
    inst_ready = 1'b1;
    do_reset();
    cycle();
    p0 = pops;
    repeat (10) cycle();
    check("stream_rate", 32'(pops - p0), 32'd10);

    // Backpressure: buffer fills to Depth, request stops, stray ack is ignored.
    inst_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    check("bp_req_low", 32'(imem_req), 32'd0);
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_buffered", 32'(buffered), 32'(Depth));
    rogue = 1'b1;
    cycle();
    rogue = 1'b0;
    inst_ready = 1'b1;
    run_until(pops + 3, 20, "bp_drain");

    // Variable latency 3, 0, 5.
    do_reset();
    lat_q.push_back(3);
    lat_q.push_back(0);
    lat_q.push_back(5);
    run_until(pops + 3, 40, "varlat");

    // Redirect while waiting on 0x8: that word is killed, fetch resumes at 0x100.
    do_reset();
    lat_q.push_back(0);
    lat_q.push_back(0);
    lat_q.push_back(8);
    repeat (3) cycle();
    check("kill_req", 32'(imem_req), 32'd1);
    check("kill_addr", imem_addr, 32'h0000_0008);
    redirect(32'h0000_0100);
    run_until(pops + 2, 40, "after_kill");

    // Redirect coinciding with ack and pop; misaligned target.
    repeat (3) cycle();
    check("ra_req", 32'(imem_req), 32'd1);
    check("ra_valid", 32'(inst_valid), 32'd1);
    redirect(32'h0000_0203);
    run_until(pops + 2, 20, "after_ra");

    // PC wrap.
    redirect(32'hFFFF_FFFC);
    run_until(pops + 3, 20, "wrap");

    // Reset in the middle of an outstanding request.
    def_lat = 5;
    repeat (3) cycle();
    check("mid_req", 32'(imem_req), 32'd1);
    do_reset();
    def_lat = 0;
    run_until(pops + 2, 20, "after_mid_reset");

    // Randomized traffic.
    do_reset();
    rand_lat = 1'b1;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      cycle();
      redirect_valid = 1'b0;
    end
    check("random_progress", 32'(pops - p0 > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
